btb_assoc_array: RTL
====================

BTB_ASSOC_ARRAY -- requirements
Module: btb_assoc_array

Interface
REQ-001 SHALL have parameter WAYS, default 4, number of ways per set (power of two, 2..8).
REQ-002 SHALL have parameter SET_BITS, default 5, index width; sets = 2**SET_BITS.
REQ-003 SHALL have parameter TAG_W, default 24, tag width.
REQ-004 SHALL have parameter DATA_W, default 32, stored target width.
REQ-005 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port lk_index  input  SET_BITS  lookup set index.
REQ-008 SHALL have port lk_tag  input  TAG_W  lookup tag.
REQ-009 SHALL have port lk_valid  input  1  lookup qualifier; a qualified hit updates PLRU.
REQ-010 SHALL have port hit  output  1  lookup hit, combinational.
REQ-011 SHALL have port hit_way  output  log2(WAYS)  hitting way; 0 on miss.
REQ-012 SHALL have port hit_data  output  DATA_W  target of hitting way; 0 on miss.
REQ-013 SHALL have port up_valid  input  1  update strobe.
REQ-014 SHALL have ports up_index/up_tag/up_data  input  SET_BITS/TAG_W/DATA_W  update fields.
REQ-015 SHALL have port flush_req  input  1  single-cycle flush request.
REQ-016 SHALL have port flush_busy  output  1  flush walk in progress.

Function
REQ-017 Lookup SHALL compare lk_tag against all valid ways of set lk_index in the same cycle; hit = any match.
REQ-018 Multiple matching ways SHALL resolve to the lowest way index.
REQ-019 Update SHALL overwrite the way whose valid tag equals up_tag; else the lowest-index invalid way; else the tree-PLRU victim; the chosen way becomes valid.
REQ-020 Each set SHALL hold WAYS-1 tree-PLRU bits; a qualified lookup hit or an update SHALL mark the touched way most-recently-used.
REQ-021 Lookup hit and update to the same set in one cycle: update's PLRU touch SHALL win; to different sets both SHALL apply.
REQ-022 Two-state FSM IDLE/FLUSH: flush_req in IDLE SHALL enter FLUSH with set counter 0 next cycle.
REQ-023 In FLUSH, one set per cycle SHALL have all valid and PLRU bits cleared; counter increments; after set 2**SET_BITS-1 return to IDLE (walk = 2**SET_BITS cycles).
REQ-024 flush_busy SHALL equal state==FLUSH; while busy hit SHALL be 0 and up_valid SHALL be ignored.
REQ-025 flush_req while busy SHALL be ignored (no restart).
REQ-026 flush_req and up_valid in the same IDLE cycle: the update SHALL be performed, then erased by the walk.
REQ-027 Tag/data arrays need no clearing; valid bits alone define content.

Reset
REQ-028 rst SHALL clear all valid and PLRU bits in one cycle, force IDLE, counter 0.
REQ-029 Outputs after reset: hit=0, hit_way=0, hit_data=0, flush_busy=0.
REQ-030 rst during a flush walk SHALL abort it; the array SHALL be fully empty the following cycle.

Configuration
REQ-031 Macro BTB_ASSOC_BYPASS_EN: when defined, an update with up_index==lk_index and up_tag==lk_tag (outside flush) SHALL produce hit=1, hit_way=way being written, hit_data=up_data in the same cycle.
REQ-032 Without BTB_ASSOC_BYPASS_EN, lookups SHALL see only pre-edge array contents.

Structure
REQ-033 Package btb_pkg SHALL hold the FSM state enum, the PLRU victim/touch functions, and default parameter constants.
REQ-034 Sub-module btb_way_store (per-way tag/data/valid storage, one write port, asynchronous read) SHALL be instantiated WAYS times.

Verification
REQ-035 Reset, then lookup index 3 tag 0x00ABCD -> hit=0, hit_way=0, hit_data=0.
REQ-036 Update index 3 tag 0x00ABCD data 0x80001000; next cycle lookup -> hit=1, hit_way=0, hit_data=0x80001000; re-update same tag data 0x80002000 -> still way 0, data 0x80002000.
REQ-037 WAYS=4: fill set 5 with tags 1,2,3,4, lookup-hit tag 1, update tag 5 -> tag 2 evicted; tags 1,3,4,5 hit.
REQ-038 Fill sets 0 and 31, pulse flush_req -> flush_busy high 32 cycles, hit=0 and updates dropped throughout, all lookups miss afterwards.
REQ-039 Assert rst at walk cycle 10 -> flush_busy=0 next cycle, all sets miss.
REQ-040 BTB_ASSOC_BYPASS_EN defined: simultaneous update/lookup index 7 tag 0x12 data 0x4000 -> hit=1, hit_data=0x4000 same cycle; undefined -> hit=0 that cycle, 1 next.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types, defaults and tree-PLRU helpers for the associative BTB array.
// The PLRU tree is stored heap-style (node 0 is the root, children of n are 2n+1 and 2n+2).
// At tree level l the branch is selected by way-index bit l, LSB at the root.
// A node bit gives the direction a victim search takes: 0 = left, 1 = right.
package btb_pkg;

    localparam int unsigned BTB_WAYS     = 4;
    localparam int unsigned BTB_SET_BITS = 5;
    localparam int unsigned BTB_TAG_W    = 24;
    localparam int unsigned BTB_DATA_W   = 32;

    // Sized for the largest supported configuration (8 ways).
    localparam int unsigned PLRU_MAX_W = 7;
    localparam int unsigned WAY_MAX_W  = 3;

    typedef enum logic {
        StIdle  = 1'b0,
        StFlush = 1'b1
    } btb_state_e;

    // Follow the node bits from the root down to the least-recently-used leaf.
    function automatic logic [WAY_MAX_W-1:0] plru_victim(input logic [PLRU_MAX_W-1:0] bits,
                                                         input int unsigned levels);
        logic [WAY_MAX_W-1:0] way;
        logic [WAY_MAX_W-1:0] mask;
        logic [3:0]           node;
        logic                 b;
        way  = '0;
        mask = 3'b001;
        node = '0;
        for (int unsigned l = 0; l < WAY_MAX_W; l++) begin
            if (l < levels) begin
                b = bits[node[2:0]];
                if (b) begin
                    way = way | mask;
                end
                mask = mask << 1;
                node = {node[2:0], 1'b0} + 4'd1 + {3'b000, b};
            end
        end
        return way;
    endfunction

    // Point every node on the path to 'way' away from it, making it most-recently-used.
    function automatic logic [PLRU_MAX_W-1:0] plru_touch(input logic [PLRU_MAX_W-1:0] bits,
                                                         input logic [WAY_MAX_W-1:0] way,
                                                         input int unsigned levels);
        logic [PLRU_MAX_W-1:0] res;
        logic [WAY_MAX_W-1:0]  w;
        logic [3:0]            node;
        res  = bits;
        w    = way;
        node = '0;
        for (int unsigned l = 0; l < WAY_MAX_W; l++) begin
            if (l < levels) begin
                res[node[2:0]] = ~w[0];
                node = {node[2:0], 1'b0} + 4'd1 + {3'b000, w[0]};
                w    = w >> 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/btb_way_store.sv
// One way of the BTB: per-set valid bit, tag and target storage.
// Single write port, one-set clear port for the flush walk, two asynchronous read ports
// (lookup side and update side). Only the valid bits are reset.
module btb_way_store #(
    parameter int unsigned SET_BITS = 5,
    parameter int unsigned TAG_W    = 24,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [SET_BITS-1:0] wr_index,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                clr_en,
    input  logic [SET_BITS-1:0] clr_index,
    input  logic [SET_BITS-1:0] lk_index,
    output logic                lk_vld,
    output logic [TAG_W-1:0]    lk_tag,
    output logic [DATA_W-1:0]   lk_data,
    input  logic [SET_BITS-1:0] up_index,
    output logic                up_vld,
    output logic [TAG_W-1:0]    up_tag
);

    localparam int unsigned SETS = 2 ** SET_BITS;

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS];

    // Valid bits: full clear on reset, one set cleared per flush step, set on write.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (clr_en) begin
                valid_q[clr_index] <= 1'b0;
            end
            if (wr_en) begin
                valid_q[wr_index] <= 1'b1;
            end
        end
    end

    // Tag and target payload; contents are meaningless unless the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign lk_vld  = valid_q[lk_index];
    assign lk_tag  = tag_q[lk_index];
    assign lk_data = data_q[lk_index];
    assign up_vld  = valid_q[up_index];
    assign up_tag  = tag_q[up_index];

endmodule

// File: rtl/btb_assoc_array.sv
// Set-associative BTB array with tree-PLRU replacement and a one-set-per-cycle flush walk.
// Optional macro BTB_ASSOC_BYPASS_EN forwards a same-cycle update to a matching lookup.
module btb_assoc_array
    import btb_pkg::*;
#(
    parameter int unsigned WAYS     = BTB_WAYS,
    parameter int unsigned SET_BITS = BTB_SET_BITS,
    parameter int unsigned TAG_W    = BTB_TAG_W,
    parameter int unsigned DATA_W   = BTB_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SET_BITS-1:0]      lk_index,
    input  logic [TAG_W-1:0]         lk_tag,
    input  logic                     lk_valid,
    output logic                     hit,
    output logic [$clog2(WAYS)-1:0]  hit_way,
    output logic [DATA_W-1:0]        hit_data,
    input  logic                     up_valid,
    input  logic [SET_BITS-1:0]      up_index,
    input  logic [TAG_W-1:0]         up_tag,
    input  logic [DATA_W-1:0]        up_data,
    input  logic                     flush_req,
    output logic                     flush_busy
);

    localparam int unsigned SETS   = 2 ** SET_BITS;
    localparam int unsigned WAY_W  = $clog2(WAYS);
    localparam int unsigned PLRU_W = WAYS - 1;

    btb_state_e                      state_q, state_d;
    logic [SET_BITS-1:0]             flush_cnt_q, flush_cnt_d;
    logic [SETS-1:0][PLRU_W-1:0]     plru_q;

    logic                            flushing;
    logic                            up_act;
    logic                            lk_touch;

    logic [WAYS-1:0]                 lk_vld;
    logic [TAG_W-1:0]                lk_tag_rd  [WAYS];
    logic [DATA_W-1:0]               lk_data_rd [WAYS];
    logic [WAYS-1:0]                 up_vld;
    logic [TAG_W-1:0]                up_tag_rd  [WAYS];

    logic                            arr_hit;
    logic [WAY_W-1:0]                arr_way;
    logic [DATA_W-1:0]               arr_data;

    logic                            up_hit;
    logic [WAY_W-1:0]                up_hit_way;
    logic                            up_free;
    logic [WAY_W-1:0]                up_free_way;
    logic [WAY_W-1:0]                up_victim;
    logic [WAY_W-1:0]                up_way;
    logic [PLRU_W-1:0]               up_plru_new;
    logic [PLRU_W-1:0]               lk_plru_new;

    assign flushing   = (state_q == StFlush);
    assign flush_busy = flushing;
    assign up_act     = up_valid && !flushing;
    assign lk_touch   = lk_valid && hit && !flushing;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        btb_way_store #(
            .SET_BITS (SET_BITS),
            .TAG_W    (TAG_W),
            .DATA_W   (DATA_W)
        ) u_store (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (up_act && (up_way == WAY_W'(w))),
            .wr_index  (up_index),
            .wr_tag    (up_tag),
            .wr_data   (up_data),
            .clr_en    (flushing),
            .clr_index (flush_cnt_q),
            .lk_index  (lk_index),
            .lk_vld    (lk_vld[w]),
            .lk_tag    (lk_tag_rd[w]),
            .lk_data   (lk_data_rd[w]),
            .up_index  (up_index),
            .up_vld    (up_vld[w]),
            .up_tag    (up_tag_rd[w])
        );
    end

    // Lookup compare across all ways; scanning downwards lets the lowest matching way win.
    always_comb begin
        arr_hit  = 1'b0;
        arr_way  = '0;
        arr_data = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (lk_vld[WAY_W'(w)] && (lk_tag_rd[WAY_W'(w)] == lk_tag)) begin
                arr_hit  = 1'b1;
                arr_way  = WAY_W'(w);
                arr_data = lk_data_rd[WAY_W'(w)];
            end
        end
    end

    // Lookup outputs, squashed during a flush walk.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_data = '0;
        if (!flushing) begin
            if (arr_hit) begin
                hit      = 1'b1;
                hit_way  = arr_way;
                hit_data = arr_data;
            end
`ifdef BTB_ASSOC_BYPASS_EN
            if (up_act && (up_index == lk_index) && (up_tag == lk_tag)) begin
                hit      = 1'b1;
                hit_way  = up_way;
                hit_data = up_data;
            end
`endif
        end
    end

    // Update way choice: matching tag, else lowest invalid way, else PLRU victim.
    always_comb begin
        up_hit      = 1'b0;
        up_hit_way  = '0;
        up_free     = 1'b0;
        up_free_way = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (up_vld[WAY_W'(w)] && (up_tag_rd[WAY_W'(w)] == up_tag)) begin
                up_hit     = 1'b1;
                up_hit_way = WAY_W'(w);
            end
            if (!up_vld[WAY_W'(w)]) begin
                up_free     = 1'b1;
                up_free_way = WAY_W'(w);
            end
        end
        up_victim = WAY_W'(plru_victim(PLRU_MAX_W'(plru_q[up_index]), WAY_W));
        if (up_hit) begin
            up_way = up_hit_way;
        end else if (up_free) begin
            up_way = up_free_way;
        end else begin
            up_way = up_victim;
        end
        up_plru_new = PLRU_W'(plru_touch(PLRU_MAX_W'(plru_q[up_index]),
                                         WAY_MAX_W'(up_way), WAY_W));
        lk_plru_new = PLRU_W'(plru_touch(PLRU_MAX_W'(plru_q[lk_index]),
                                         WAY_MAX_W'(hit_way), WAY_W));
    end

    // PLRU state: an update's touch takes precedence over a lookup touch on the same set.
    always_ff @(posedge clk) begin
        if (rst) begin
            plru_q <= '0;
        end else if (flushing) begin
            plru_q[flush_cnt_q] <= '0;
        end else begin
            if (up_act) begin
                plru_q[up_index] <= up_plru_new;
            end
            if (lk_touch && !(up_act && (up_index == lk_index))) begin
                plru_q[lk_index] <= lk_plru_new;
            end
        end
    end

    // Flush FSM next state: a request is only accepted while idle.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (flush_req) begin
                    state_d     = StFlush;
                    flush_cnt_d = '0;
                end
            end
            StFlush: begin
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == '1) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Flush FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule
